fminmax_reduce: RTL and testbench

Streaming floating-point min/max reducer for the FPU datapath. Accepts a packet of IEEE-754 single-precision values over a valid/ready stream terminated by `in_last`, and emits the minimum or maximum value of the packet and its index. Uses the FPU's standard ordering rule: any operand with a zero exponent field is treated as zero, so ±0 and denormals all compare equal. Sits downstream of the FPU result bus, feeding selection and clamping logic.

---
 rtl/fpu_cmp_pkg.sv | 46 ++++
 rtl/fcmp_lt.sv | 15 +
 rtl/fminmax_reduce.sv | 114 +++++++++++
 tb/tb_fminmax_reduce.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fpu_cmp_pkg.sv
// fpu_cmp_pkg
// Shared definitions for the floating-point min/max reducer.
//   red_state_t : reducer FSM states (FIRST, ACC, DONE)
//   SIGN_BIT, EXP_MSB, EXP_LSB : single-precision field positions
//   f_lt(a, b)  : FPU ordering "a < b". An operand with a zero exponent
//                 field counts as zero, and NaNs are ordered by raw bits.
package fpu_cmp_pkg;

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    ACC   = 2'd1,
    DONE  = 2'd2
  } red_state_t;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;

  // Sign/magnitude compare on the raw bits. If both exponent fields are
  // zero, the operands are equal (+0, -0 and all denormals). If only one
  // is zero-exponent, the ordinary magnitude compare already places it
  // correctly relative to the other operand.
  function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
    logic a_zero;
    logic b_zero;
    logic a_neg;
    logic b_neg;
    logic res;
    a_zero = (a[EXP_MSB:EXP_LSB] == '0);
    b_zero = (b[EXP_MSB:EXP_LSB] == '0);
    a_neg  = a[SIGN_BIT];
    b_neg  = b[SIGN_BIT];
    if (a_zero && b_zero)
      res = 1'b0;
    else if (a_neg && !b_neg)
      res = 1'b1;
    else if (!a_neg && b_neg)
      res = 1'b0;
    else if (a_neg)
      res = (a[EXP_MSB:0] > b[EXP_MSB:0]);
    else
      res = (a[EXP_MSB:0] < b[EXP_MSB:0]);
    return res;
  endfunction

endpackage

// File: rtl/fcmp_lt.sv
// fcmp_lt
// Combinational FPU "less than" comparator.
//   a, b : single-precision operands
//   lt   : 1 when a orders strictly below b
module fcmp_lt
  import fpu_cmp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  assign lt = f_lt(a, b);

endmodule

// File: rtl/fminmax_reduce.sv
// fminmax_reduce
// Streaming min/max reducer. It takes a valid/ready packet of
// single-precision values ended by in_last and returns the minimum
// (mode=0) or maximum (mode=1) element together with its index.
//   clk, rst             : clock, synchronous active-high reset
//   mode                 : 0=min, 1=max, sampled on the first beat only
//   in_valid/in_ready    : input handshake; in_data operand; in_last end of packet
//   out_valid/out_ready  : result handshake
//   out_data             : selected operand (unmodified bits)
//   out_idx              : zero-based position of the selected operand
//   out_sat              : packet ran past 2^IDX_W beats, so index tracking froze
module fminmax_reduce
  import fpu_cmp_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_sat
);

  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  red_state_t       state;
  red_state_t       next_state;
  logic [31:0]      best;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W-1:0] cnt;
  logic             sat;
  logic             mode_r;
  // Set once the beat at index CNT_MAX has been taken. Any later beat is
  // past the trackable range and marks the packet saturated.
  logic             cnt_full;

  logic             accept;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic             cand_better;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign out_data  = best;
  assign out_idx   = best_idx;
  assign out_sat   = sat;

  // A single comparator serves both modes. For max the operands are
  // swapped, so "candidate better" is always the comparator output.
  assign cmp_a = mode_r ? best : in_data;
  assign cmp_b = mode_r ? in_data : best;

  fcmp_lt u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (cand_better)
  );

  always_comb begin
    next_state = state;
    case (state)
      FIRST:   if (accept && in_last) next_state = DONE;
               else if (accept)       next_state = ACC;
      ACC:     if (accept && in_last) next_state = DONE;
      DONE:    if (out_ready)         next_state = FIRST;
      default: next_state = FIRST;
    endcase
  end

  // The result registers are updated only by accepted beats. While in
  // DONE they stay stable, which holds the output under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FIRST;
      best     <= '0;
      best_idx <= '0;
      cnt      <= '0;
      sat      <= 1'b0;
      mode_r   <= 1'b0;
      cnt_full <= 1'b0;
    end else begin
      state <= next_state;
      if (accept && state == FIRST) begin
        best     <= in_data;
        best_idx <= '0;
        cnt      <= IDX_W'(1);
        mode_r   <= mode;
        sat      <= 1'b0;
        cnt_full <= 1'b0;
      end else if (accept && state == ACC) begin
        if (cand_better) begin
          best <= in_data;
          if (!cnt_full)
            best_idx <= cnt;
        end
        if (cnt_full)
          sat <= 1'b1;
        else if (cnt == CNT_MAX)
          cnt_full <= 1'b1;
        else
          cnt <= cnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fminmax_reduce.sv
// tb_fminmax_reduce
// Directed, table-driven bench for fminmax_reduce, built with IDX_W=2 so
// that saturation can be reached with short packets.
module tb_fminmax_reduce;

  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_sat;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string            name;
    int               len;
    logic             mode;
    logic             toggle;
    logic [5:0][31:0] data;
    logic [31:0]      exp_data;
    logic [IDX_W-1:0] exp_idx;
    logic             exp_sat;
  } vec_t;

  vec_t vecs[$];

  fminmax_reduce #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // One comparison. It prints a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input int len, input logic m, input logic tg,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] d3, input logic [31:0] d4, input logic [31:0] d5,
                        input logic [31:0] ed, input logic [IDX_W-1:0] ei, input logic es);
    vec_t v;
    v.name = name; v.len = len; v.mode = m; v.toggle = tg;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
    v.data[3] = d3; v.data[4] = d4; v.data[5] = d5;
    v.exp_data = ed; v.exp_idx = ei; v.exp_sat = es;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one packet. mode is correct only on beat 0. When toggle is set,
  // later beats carry the opposite mode to show that it is ignored.
  task automatic applyStimulus(input vec_t v);
    int waits;
    for (int i = 0; i < v.len; i++) begin
      in_valid = 1'b1;
      in_data  = v.data[i];
      in_last  = (i == v.len - 1);
      mode     = (i == 0) ? v.mode : (v.toggle ? ~v.mode : v.mode);
      waits = 0;
      while (!in_ready && waits < 20) begin
        tick();
        waits++;
      end
      checkOutput({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Must be called #1 after the edge that accepted the last beat.
  task automatic finishPacket(input string name, input logic [31:0] ed,
                              input logic [IDX_W-1:0] ei, input logic es);
    int waits;
    checkOutput({name, "_latency_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_data"}, out_data, ed);
    checkOutput({name, "_idx"}, 32'(out_idx), 32'(ei));
    checkOutput({name, "_sat"}, 32'(out_sat), 32'(es));
    waits = 0;
    while (!out_valid && waits < 20) begin
      tick();
      waits++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({name, "_in_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t bp;
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

    addVec("min_basic", 3, 1'b0, 1'b0, 32'h40400000, 32'hBF800000, 32'h40000000, 0, 0, 0,
           32'hBF800000, 2'd1, 1'b0);
    addVec("max_toggle", 3, 1'b1, 1'b1, 32'h40400000, 32'hBF800000, 32'h40000000, 0, 0, 0,
           32'h40400000, 2'd0, 1'b0);
    addVec("zero_tie_min", 3, 1'b0, 1'b0, 32'h80000000, 32'h00000000, 32'h00000001, 0, 0, 0,
           32'h80000000, 2'd0, 1'b0);
    addVec("zero_tie_max", 3, 1'b1, 1'b0, 32'h80000000, 32'h00000000, 32'h00000001, 0, 0, 0,
           32'h80000000, 2'd0, 1'b0);
    addVec("full_4_nosat", 4, 1'b0, 1'b0, 32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000, 0, 0,
           32'h40000000, 2'd3, 1'b0);
    addVec("saturate_6", 6, 1'b0, 1'b0, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h3F000000,
           32'h40800000, 32'hBF800000, 32'hBF800000, 2'd3, 1'b1);
    addVec("neg_min", 3, 1'b0, 1'b0, 32'hC0000000, 32'hC0400000, 32'hBF800000, 0, 0, 0,
           32'hC0400000, 2'd1, 1'b0);
    addVec("max_tie_keep", 3, 1'b1, 1'b0, 32'hC0000000, 32'h3F800000, 32'h3F800000, 0, 0, 0,
           32'h3F800000, 2'd1, 1'b0);
    addVec("single_inf", 1, 1'b1, 1'b0, 32'h7F800000, 0, 0, 0, 0, 0,
           32'h7F800000, 2'd0, 1'b0);
    addVec("nan_max", 2, 1'b1, 1'b0, 32'h7FC00000, 32'h7F800000, 0, 0, 0, 0,
           32'h7FC00000, 2'd0, 1'b0);
    addVec("negnan_min", 2, 1'b0, 1'b0, 32'h3F800000, 32'hFFC00000, 0, 0, 0, 0,
           32'hFFC00000, 2'd1, 1'b0);

    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_data", out_data, 32'h0);
    checkOutput("reset_out_idx", 32'(out_idx), 32'd0);
    checkOutput("reset_out_sat", 32'(out_sat), 32'd0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      finishPacket(vecs[k].name, vecs[k].exp_data, vecs[k].exp_idx, vecs[k].exp_sat);
    end

    // Backpressure: a held result must stay still with the input closed.
    bp.name = "bp_single"; bp.len = 1; bp.mode = 1'b0; bp.toggle = 1'b0;
    bp.data = '0; bp.data[0] = 32'hC2C80000;
    applyStimulus(bp);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_data", out_data, 32'hC2C80000);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    checkOutput("bp_hs_in_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    checkOutput("bp_after_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_after_out_valid", 32'(out_valid), 32'd0);
    bp.name = "bp_b2b"; bp.len = 2; bp.data[0] = 32'h40000000; bp.data[1] = 32'hC0800000;
    applyStimulus(bp);
    finishPacket("bp_b2b", 32'hC0800000, 2'd1, 1'b0);

    // Reset mid-packet: the aborted beats must leave no residue.
    mode = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    in_data = 32'hBF800000; tick();
    in_data = 32'hC1200000; tick();
    in_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_out_data", out_data, 32'h0);
    bp.name = "rst_new"; bp.len = 1; bp.mode = 1'b1; bp.data[0] = 32'h3F800000;
    applyStimulus(bp);
    finishPacket("rst_new", 32'h3F800000, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
